// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for serial_adder.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand request and busy/done/result response.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef SERIAL_ADDER_SUB_EN
   modport master (
      output start, a, b, sub,
      input  busy, done, sum, cout
   );
   modport slave (
      input  start, a, b, sub,
      output busy, done, sum, cout
   );
`else
   modport master (
      output start, a, b,
      input  busy, done, sum, cout
   );
   modport slave (
      input  start, a, b,
      output busy, done, sum, cout
   );
`endif

endinterface

// File: rtl/serial_adder_full_add_cell.sv
// full_add_cell: combinational 1-bit full adder.
// Shared by add and (SERIAL_ADDER_SUB_EN) subtract modes.
module full_add_cell (
   input  logic x_i,
   input  logic y_i,
   input  logic z_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = x_i ^ y_i ^ z_i;
   assign c_o = (x_i & y_i) | (z_i & (x_i ^ y_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add a sub port selecting a - b.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus_io
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             s_w, c_w;
   logic             sub_w;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_w = bus_io.sub;
`else
   assign sub_w = 1'b0;
`endif

   full_add_cell u_fa (
      .x_i (a_q[0]),
      .y_i (b_q[0]),
      .z_i (carry_q),
      .s_o (s_w),
      .c_o (c_w)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus_io.start) begin
               // subtract = a + ~b + 1, carry-in supplies the +1
               a_d     = bus_io.a;
               b_d     = sub_w ? ~bus_io.b : bus_io.b;
               carry_d = sub_w;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            res_d   = {s_w, res_q[WIDTH-1:1]};
            carry_d = c_w;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {s_w, res_q[WIDTH-1:1]};
               cout_d  = c_w;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus_io.busy = (state_q == ST_RUN);
   assign bus_io.done = (state_q == ST_DONE);
   assign bus_io.sum  = sum_q;
   assign bus_io.cout = cout_q;

endmodule
